// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the dual-port data-memory controller.
package mem_ctrl_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    MW_NONE = 2'b00,
    MW_SB   = 2'b01,
    MW_SH   = 2'b10,
    MW_SW   = 2'b11
  } mw_t;

  localparam logic [2:0] SL_LB  = 3'b000;
  localparam logic [2:0] SL_LH  = 3'b001;
  localparam logic [2:0] SL_LW  = 3'b010;
  localparam logic [2:0] SL_LBU = 3'b100;
  localparam logic [2:0] SL_LHU = 3'b101;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
  typedef enum logic {GNT_CPU, GNT_HOST} grant_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  // Transaction latched at grant time
  typedef struct packed {
    grant_t            grant;
    mw_t               memwrite;
    logic [2:0]        sizeload;
    logic [1:0]        off;
    logic [DATA_W-1:0] wdata;
    logic              trap;
  } mem_req_t;

  // Undefined load codes fall through to word size
  function automatic size_t load_size(input logic [2:0] sl);
    case (sl)
      SL_LB, SL_LBU: return SZ_BYTE;
      SL_LH, SL_LHU: return SZ_HALF;
      default:       return SZ_WORD;
    endcase
  endfunction

  function automatic size_t access_size(input mw_t mw, input logic [2:0] sl);
    case (mw)
      MW_SB:   return SZ_BYTE;
      MW_SH:   return SZ_HALF;
      MW_SW:   return SZ_WORD;
      default: return load_size(sl);
    endcase
  endfunction

  function automatic logic [1:0] align_off(input logic [1:0] off, input size_t sz);
    case (sz)
      SZ_HALF: return {off[1], 1'b0};
      SZ_WORD: return 2'b00;
      default: return off;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] off, input size_t sz);
    return ((sz == SZ_HALF) && off[0]) || ((sz == SZ_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Store lane enables / data replication and load byte-half extract with extension.
module mem_lane_align
  import mem_ctrl_pkg::*;
(
  input  mw_t               memwrite,
  input  logic [2:0]        sizeload,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rword,
  output logic [3:0]        be_c,
  output logic [DATA_W-1:0] wdata_c,
  output logic [DATA_W-1:0] ld_data_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    be_c    = 4'b0000;
    wdata_c = wdata;
    case (memwrite)
      MW_SB: begin
        be_c    = 4'b0001 << off;
        wdata_c = {4{wdata[7:0]}};
      end
      MW_SH: begin
        be_c    = off[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata[15:0]}};
      end
      MW_SW:   be_c = 4'b1111;
      default: be_c = 4'b0000;
    endcase
  end

  // Bit 2 of the load code selects zero-extension
  always_comb begin
    byte_c    = rword[{off, 3'b000} +: 8];
    half_c    = off[1] ? rword[31:16] : rword[15:0];
    ld_data_c = rword;
    case (load_size(sizeload))
      SZ_BYTE: ld_data_c = sizeload[2] ? {24'h0, byte_c} : {{24{byte_c[7]}}, byte_c};
      SZ_HALF: ld_data_c = sizeload[2] ? {16'h0, half_c} : {{16{half_c[15]}}, half_c};
      default: ld_data_c = rword;
    endcase
  end

endmodule

// File: rtl/dual_port_mem_ctrl.sv
// CPU/host arbitrated single-port RAM controller with sized loads/stores.
// Define MEM_CTRL_MISALIGN_TRAP_EN to trap misaligned CPU accesses instead of aligning them.
module dual_port_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [1:0]  cpu_memwrite,
  input  logic [2:0]  cpu_sizeload,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic [31:0] host_rdata,
  output logic        host_ack
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  state_t           state_q, state_d;
  grant_t           last_grant_q, gnt_c;
  mem_req_t         req_q, req_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  size_t            cpu_size_c;
  logic [1:0]       cpu_off_c;
  logic             cpu_trap_c;
  logic [3:0]       be_c;
  logic [31:0]      wdata_rep_c, ld_data_c, ram_rdata_c;
  logic             ram_we_c;
  logic             cpu_ack_d, host_ack_d, cpu_err_d;
  logic [31:0]      cpu_rdata_d, host_rdata_d;
  logic             unused_addr_c;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  assign unused_addr_c = ^{cpu_addr[31:IDX_W+2], host_addr[31:IDX_W+2], host_addr[1:0]};
  assign cpu_size_c    = access_size(mw_t'(cpu_memwrite), cpu_sizeload);

`ifdef MEM_CTRL_MISALIGN_TRAP_EN
  assign cpu_off_c  = cpu_addr[1:0];
  assign cpu_trap_c = is_misaligned(cpu_addr[1:0], cpu_size_c);
`else
  assign cpu_off_c  = align_off(cpu_addr[1:0], cpu_size_c);
  assign cpu_trap_c = 1'b0;
`endif

  // Round-robin: on contention the port that did not win last time goes first
  always_comb begin
    if (cpu_req && host_req) gnt_c = (last_grant_q == GNT_CPU) ? GNT_HOST : GNT_CPU;
    else if (cpu_req)        gnt_c = GNT_CPU;
    else                     gnt_c = GNT_HOST;
  end

  always_comb begin
    req_d.grant = gnt_c;
    if (gnt_c == GNT_CPU) begin
      req_d.memwrite = mw_t'(cpu_memwrite);
      req_d.sizeload = cpu_sizeload;
      req_d.off      = cpu_off_c;
      req_d.wdata    = cpu_wdata;
      req_d.trap     = cpu_trap_c;
      idx_d          = cpu_addr[IDX_W+1:2];
    end else begin
      req_d.memwrite = host_we ? MW_SW : MW_NONE;
      req_d.sizeload = SL_LW;
      req_d.off      = 2'b00;
      req_d.wdata    = host_wdata;
      req_d.trap     = 1'b0;
      idx_d          = host_addr[IDX_W+1:2];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GNT_HOST;
      req_q        <= '0;
      idx_q        <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && (cpu_req || host_req)) begin
        req_q        <= req_d;
        idx_q        <= idx_d;
        last_grant_q <= gnt_c;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cpu_req || host_req) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  mem_lane_align u_lane_align (
    .memwrite  (req_q.memwrite),
    .sizeload  (req_q.sizeload),
    .off       (req_q.off),
    .wdata     (req_q.wdata),
    .rword     (ram_rdata_c),
    .be_c      (be_c),
    .wdata_c   (wdata_rep_c),
    .ld_data_c (ld_data_c)
  );

  // Write enable depends on state so a reset before the ACCESS edge blocks the commit
  assign ram_we_c    = (state_q == ST_ACCESS) && (req_q.memwrite != MW_NONE) && !req_q.trap;
  assign ram_rdata_c = mem[idx_q];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_we_c && be_c[b]) mem[idx_q][8*b +: 8] <= wdata_rep_c[8*b +: 8];
    end
  end

  always_comb begin
    cpu_ack_d    = 1'b0;
    host_ack_d   = 1'b0;
    cpu_err_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata;
    host_rdata_d = host_rdata;
    if (state_q == ST_ACCESS) begin
      if (req_q.grant == GNT_CPU) begin
        cpu_ack_d = 1'b1;
        if (req_q.trap) begin
          cpu_err_d   = 1'b1;
          cpu_rdata_d = '0;
        end else if (req_q.memwrite == MW_NONE) begin
          cpu_rdata_d = ld_data_c;
        end
      end else begin
        host_ack_d = 1'b1;
        if (req_q.memwrite == MW_NONE) host_rdata_d = ram_rdata_c;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_ack    <= 1'b0;
      host_ack   <= 1'b0;
      cpu_err    <= 1'b0;
      cpu_rdata  <= '0;
      host_rdata <= '0;
    end else begin
      cpu_ack    <= cpu_ack_d;
      host_ack   <= host_ack_d;
      cpu_err    <= cpu_err_d;
      cpu_rdata  <= cpu_rdata_d;
      host_rdata <= host_rdata_d;
    end
  end

endmodule
